// File: rtl/i2c_pkg.sv
// Shared definitions for the byte-level I2C master: command encodings,
// FSM states and the per-slot SDA drive rule.
// Imported by i2c_bit_timer and i2c_master_core.
package i2c_pkg;

  localparam logic [1:0] I2C_CMD_START = 2'b00;
  localparam logic [1:0] I2C_CMD_STOP  = 2'b01;
  localparam logic [1:0] I2C_CMD_WRITE = 2'b10;
  localparam logic [1:0] I2C_CMD_READ  = 2'b11;

  // Slots 0-7 carry data, slot 8 is the ACK slot.
  localparam logic [3:0] I2C_ACK_SLOT = 4'd8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_STOP,
    ST_BIT
  } i2c_state_t;

  // SDA pull-down for a bit slot. WRITE drives zero bits until arbitration
  // is lost and releases the ACK slot; READ releases data slots and drives
  // ack_in in the ACK slot.
  function automatic logic slot_sda_oe(input logic [3:0] slot, input logic rd,
                                       input logic bit7, input logic lost,
                                       input logic ack_bit);
    if (slot == I2C_ACK_SLOT) return rd && !ack_bit;
    return !rd && !bit7 && !lost;
  endfunction

endpackage

// File: rtl/i2c_bit_timer.sv
// Quarter-period divider: 2^DW clk per quarter, four quarters per bit.
// Latency: qtr_end is combinational on the last count of each quarter.
// Backpressure: in quarter 2 the count stalls while synced SCL is low (stretch).
// Ports: clk/rst; clr restarts at Q0; run enables counting; scl_hi is synced
// SCL; qtr = quarter index; qtr_first / qtr_end mark first / last cycle.
module i2c_bit_timer
  import i2c_pkg::*;
#(
  parameter int DW = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       run,
  input  logic       scl_hi,
  output logic [1:0] qtr,
  output logic       qtr_first,
  output logic       qtr_end
);

  logic [DW-1:0] cnt;
  logic          hold;

  // The first two counts of Q2 cover the synchroniser delay after SCL is
  // released, so an unstretched quarter keeps its nominal length and a
  // stretch lengthens it by exactly the time the slave holds SCL low.
  // Needs DW >= 2.
  assign hold      = (qtr == 2'd2) && (cnt > DW'(1)) && !scl_hi;
  assign qtr_end   = run && !hold && (&cnt);
  assign qtr_first = run && (cnt == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
      qtr <= 2'd0;
    end else if (clr) begin
      cnt <= '0;
      qtr <= 2'd0;
    end else if (run && !hold) begin
      cnt <= cnt + DW'(1);
      if (&cnt) qtr <= qtr + 2'd1;
    end
  end

endmodule

// File: rtl/i2c_master_core.sv
// Single-master byte-level I2C engine: START, STOP, WRITE byte, READ byte.
// Latency: START/STOP 4 quarters, WRITE/READ 36 quarters; ready rises as the last quarter ends.
// Backpressure: one command at a time via ready/stb; SCL stretching in Q2 lengthens the command.
// Ports: scl_oe/sda_oe pull pads low, scl_i/sda_i pad levels; cmd/data_in/
// ack_in/stb command input; data_out/ack_out/err_out status; ready = idle.
module i2c_master_core
  import i2c_pkg::*;
#(
  parameter int DW = 4
) (
  input  logic       clk,
  input  logic       rst,
  output logic       scl_oe,
  input  logic       scl_i,
  output logic       sda_oe,
  input  logic       sda_i,
  input  logic [7:0] data_in,
  input  logic       ack_in,
  input  logic [1:0] cmd,
  input  logic       stb,
  output logic [7:0] data_out,
  output logic       ack_out,
  output logic       err_out,
  output logic       ready
);

  i2c_state_t state;
  logic       scl_m, scl_s, sda_m, sda_s;
  logic [1:0] qtr;
  logic       qtr_first, qtr_end;
  logic       accept, sample;
  logic [3:0] slot;
  logic [7:0] sh;       // tx byte for WRITE, rx byte for READ
  logic       rd, ack_bit, lost;

  // Pad synchronisers; reset to the idle (pulled-up) level.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scl_m <= 1'b1;
      scl_s <= 1'b1;
      sda_m <= 1'b1;
      sda_s <= 1'b1;
    end else begin
      scl_m <= scl_i;
      scl_s <= scl_m;
      sda_m <= sda_i;
      sda_s <= sda_m;
    end
  end

  assign accept = ready && stb;
  assign sample = (state == ST_BIT) && (qtr == 2'd3) && qtr_first;

  i2c_bit_timer #(.DW(DW)) u_timer (
    .clk       (clk),
    .rst       (rst),
    .clr       (accept),
    .run       (state != ST_IDLE),
    .scl_hi    (scl_s),
    .qtr       (qtr),
    .qtr_first (qtr_first),
    .qtr_end   (qtr_end)
  );

  // Each quarter-end edge loads the pad drive for the following quarter,
  // so scl_oe/sda_oe are registered and line up with the divider.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      ready    <= 1'b1;
      scl_oe   <= 1'b0;
      sda_oe   <= 1'b0;
      data_out <= 8'h00;
      ack_out  <= 1'b0;
      err_out  <= 1'b0;
      slot     <= 4'd0;
      sh       <= 8'h00;
      rd       <= 1'b0;
      ack_bit  <= 1'b0;
      lost     <= 1'b0;
    end else if (accept) begin
      ready   <= 1'b0;
      err_out <= 1'b0;
      sh      <= data_in;
      rd      <= (cmd == I2C_CMD_READ);
      ack_bit <= ack_in;
      slot    <= 4'd0;
      lost    <= 1'b0;
      scl_oe  <= 1'b1;
      case (cmd)
        I2C_CMD_START: begin state <= ST_START; sda_oe <= 1'b0; end
        I2C_CMD_STOP:  begin state <= ST_STOP;  sda_oe <= 1'b1; end
        default: begin
          state  <= ST_BIT;
          sda_oe <= slot_sda_oe(4'd0, cmd == I2C_CMD_READ, data_in[7], 1'b0, ack_in);
        end
      endcase
    end else begin
      if (sample && slot != I2C_ACK_SLOT) begin
        sh <= {sh[6:0], sda_s};
        // A released '1' read back low means another master owns the bus.
        if (!rd && sh[7] && !lost && !sda_s) begin
          lost    <= 1'b1;
          err_out <= 1'b1;
        end
      end
      if (sample && slot == I2C_ACK_SLOT && !rd) ack_out <= sda_s;

      if (qtr_end) begin
        case (state)
          ST_START: begin
            if (qtr == 2'd0)      scl_oe <= 1'b0;
            else if (qtr == 2'd1) sda_oe <= 1'b1;
            else if (qtr == 2'd2) scl_oe <= 1'b1;
            else begin
              state <= ST_IDLE;
              ready <= 1'b1;
            end
          end
          ST_STOP: begin
            if (qtr == 2'd0)      scl_oe <= 1'b0;
            else if (qtr == 2'd1) sda_oe <= 1'b0;
            else if (qtr == 2'd3) begin
              if (!sda_s) err_out <= 1'b1;
              state <= ST_IDLE;
              ready <= 1'b1;
            end
          end
          ST_BIT: begin
            if (qtr == 2'd1) scl_oe <= 1'b0;
            else if (qtr == 2'd3) begin
              scl_oe <= 1'b1;
              if (slot == I2C_ACK_SLOT) begin
                sda_oe <= 1'b0;
                state  <= ST_IDLE;
                ready  <= 1'b1;
                if (rd) data_out <= sh;
              end else begin
                slot   <= slot + 4'd1;
                sda_oe <= slot_sda_oe(slot + 4'd1, rd, sh[7], lost, ack_bit);
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_master_core.sv
// Scoreboard bench for i2c_master_core with DW = 2 (quarter = 4 clk).
// Pads are pulled up; a small slave model ACKs, returns bytes, stretches SCL
// and pulls SDA to collide with the master, depending on slv_mode.
module tb_i2c_master_core;
  import i2c_pkg::*;

  localparam int DW = 2;
  localparam int SLV_NONE = 0, SLV_ACK = 1, SLV_TX = 2, SLV_ARB = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       scl_oe, sda_oe, scl_i, sda_i;
  logic [7:0] data_in, data_out;
  logic       ack_in, ack_out, err_out, ready, stb;
  logic [1:0] cmd;

  always #5 clk = ~clk;

  // slave / bus model state
  int         slv_mode = SLV_NONE;
  logic [7:0] slv_byte = 8'h00;
  logic       slv_sda_low = 1'b0;
  logic       slv_scl_low;
  bit         stretch_arm = 1'b0;
  bit         stretch_done = 1'b0;
  int         stretch_cnt = 0;
  int         rise_cnt = 0;
  int         starts = 0, stops = 0;
  logic       scl_q = 1'b1, sda_q = 1'b1, scl_oe_q = 1'b0;
  logic [15:0] cap_sda = '0, cap_oe = '0;

  assign slv_scl_low = (stretch_cnt != 0) ||
                       (stretch_arm && !stretch_done && rise_cnt == 3 && scl_oe_q && !scl_oe);
  assign scl_i = !(scl_oe || slv_scl_low);
  assign sda_i = !(sda_oe || slv_sda_low);

  i2c_master_core #(.DW(DW)) dut (
    .clk      (clk),
    .rst      (rst),
    .scl_oe   (scl_oe),
    .scl_i    (scl_i),
    .sda_oe   (sda_oe),
    .sda_i    (sda_i),
    .data_in  (data_in),
    .ack_in   (ack_in),
    .cmd      (cmd),
    .stb      (stb),
    .data_out (data_out),
    .ack_out  (ack_out),
    .err_out  (err_out),
    .ready    (ready)
  );

  function automatic logic slv_pull(input int mode, input logic [7:0] b, input int n);
    if (mode == SLV_ACK) return n == 8;
    if (mode == SLV_ARB) return n == 1;
    if (mode == SLV_TX && n < 8) return !b[7-n];
    return 1'b0;
  endfunction

  // Bus observer + slave: counts SCL rises per command, captures SDA at each
  // rise, flags START/STOP conditions and changes slave SDA only while SCL is low.
  always @(posedge clk) begin
    if (ready && stb) rise_cnt <= 0;
    else if (scl_i && !scl_q) begin
      if (rise_cnt < 16) begin
        cap_sda[rise_cnt] <= sda_i;
        cap_oe[rise_cnt]  <= sda_oe;
      end
      rise_cnt <= rise_cnt + 1;
    end
    if (!scl_i) slv_sda_low <= slv_pull(slv_mode, slv_byte, rise_cnt);
    if (scl_q && scl_i && sda_q && !sda_i) starts <= starts + 1;
    if (scl_q && scl_i && !sda_q && sda_i) stops <= stops + 1;
    if (stretch_cnt > 0) stretch_cnt <= stretch_cnt - 1;
    else if (stretch_arm && !stretch_done && rise_cnt == 3 && scl_oe_q && !scl_oe) begin
      stretch_cnt  <= 19;
      stretch_done <= 1'b1;
    end
    scl_q    <= scl_i;
    sda_q    <= sda_i;
    scl_oe_q <= scl_oe;
  end

  int n_vec = 0, n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic [15:0] cyc;
    logic [7:0]  dat;
    logic        ack;
    logic        err;
    logic        cd;   // compare data_out
    logic        ca;   // compare ack_out
    logic        ctx;  // compare byte seen on SDA at SCL rises
    logic [7:0]  tx;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];

  function automatic exp_t mk(input int cyc, input logic [7:0] dat, input logic ack,
                              input logic err, input logic cd, input logic ca,
                              input logic ctx, input logic [7:0] tx);
    exp_t e;
    e.cyc = 16'(cyc); e.dat = dat; e.ack = ack; e.err = err;
    e.cd = cd; e.ca = ca; e.ctx = ctx; e.tx = tx;
    return e;
  endfunction

  task automatic do_cmd(input string name, input logic [1:0] c, input logic [7:0] d,
                        input logic a, input exp_t e, input bit poke);
    int cyc;
    exp_t got;
    string nm;
    logic [7:0] seen;
    exp_q.push_back(e);
    name_q.push_back(name);
    @(negedge clk);
    cmd = c; data_in = d; ack_in = a; stb = 1'b1;
    @(negedge clk);
    stb = 1'b0; cmd = ~c; data_in = ~d; ack_in = ~a;
    cyc = 0;
    while (ready == 1'b0 && cyc < 2000) begin
      cyc++;
      if (poke && cyc == 20) begin stb = 1'b1; cmd = I2C_CMD_START; end
      if (poke && cyc == 26) stb = 1'b0;
      @(negedge clk);
    end
    got = exp_q.pop_front();
    nm  = name_q.pop_front();
    check({nm, ".cycles"}, cyc, 32'(got.cyc));
    check({nm, ".err"}, err_out, got.err);
    if (got.cd) check({nm, ".data"}, data_out, got.dat);
    if (got.ca) check({nm, ".ack"}, ack_out, got.ack);
    if (got.ctx) begin
      for (int i = 0; i < 8; i++) seen[7-i] = cap_sda[i];
      check({nm, ".txbits"}, seen, got.tx);
    end
  endtask

  int s0, p0;

  initial begin
    stb = 1'b0; cmd = 2'b00; data_in = 8'h00; ack_in = 1'b0;
    repeat (3) @(negedge clk);
    check("rst.ready", ready, 1);
    check("rst.scl_oe", scl_oe, 0);
    check("rst.sda_oe", sda_oe, 0);
    check("rst.data_out", data_out, 0);
    check("rst.ack_out", ack_out, 0);
    check("rst.err_out", err_out, 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // START / STOP on an idle bus
    s0 = starts;
    do_cmd("start", I2C_CMD_START, 8'h00, 1'b0, mk(16, 0, 0, 0, 0, 0, 0, 0), 1'b0);
    check("start.cond", starts - s0, 1);
    check("start.end_lines", {scl_i, sda_i}, 2'b00);
    p0 = stops;
    do_cmd("stop", I2C_CMD_STOP, 8'h00, 1'b0, mk(16, 0, 0, 0, 0, 0, 0, 0), 1'b0);
    check("stop.cond", stops - p0, 1);
    check("stop.idle_bus", {scl_i, sda_i}, 2'b11);

    // WRITE with ACK, WRITE with NAK, READ with busy strobe
    do_cmd("start2", I2C_CMD_START, 8'h00, 1'b0, mk(16, 0, 0, 0, 0, 0, 0, 0), 1'b0);
    slv_mode = SLV_ACK;
    s0 = starts; p0 = stops;
    do_cmd("wr30", I2C_CMD_WRITE, 8'h30, 1'b0, mk(144, 0, 0, 0, 0, 1, 1, 8'h30), 1'b0);
    check("wr30.no_spurious_cond", (starts - s0) + (stops - p0), 0);
    slv_mode = SLV_NONE;
    do_cmd("wr31", I2C_CMD_WRITE, 8'h31, 1'b0, mk(144, 0, 1, 0, 0, 1, 1, 8'h31), 1'b0);
    slv_mode = SLV_TX; slv_byte = 8'hA5;
    do_cmd("rdA5", I2C_CMD_READ, 8'h00, 1'b1, mk(144, 8'hA5, 0, 0, 1, 0, 0, 0), 1'b1);
    check("rdA5.slot8_oe", cap_oe[8], 0);
    check("rdA5.slot8_sda", cap_sda[8], 1);
    repeat (3) @(negedge clk);
    check("rdA5.busy_stb_ignored", ready, 1);
    slv_mode = SLV_NONE;
    do_cmd("stop2", I2C_CMD_STOP, 8'h00, 1'b0, mk(16, 0, 0, 0, 0, 0, 0, 0), 1'b0);

    // Clock stretching in bit 3
    do_cmd("start3", I2C_CMD_START, 8'h00, 1'b0, mk(16, 0, 0, 0, 0, 0, 0, 0), 1'b0);
    stretch_arm = 1'b1;
    do_cmd("wr5A_stretch", I2C_CMD_WRITE, 8'h5A, 1'b0, mk(164, 0, 1, 0, 0, 1, 1, 8'h5A), 1'b0);
    stretch_arm = 1'b0;

    // Arbitration loss in slot 1
    slv_mode = SLV_ARB;
    do_cmd("wrFF_arb", I2C_CMD_WRITE, 8'hFF, 1'b0, mk(144, 0, 1, 1, 0, 1, 0, 0), 1'b0);
    for (int i = 0; i < 8; i++) check($sformatf("wrFF_arb.sda_oe%0d", i), cap_oe[i], 0);
    slv_mode = SLV_NONE;
    do_cmd("stop3", I2C_CMD_STOP, 8'h00, 1'b0, mk(16, 0, 0, 0, 0, 0, 0, 0), 1'b0);

    // Reset in the middle of a WRITE
    @(negedge clk);
    cmd = I2C_CMD_WRITE; data_in = 8'h00; stb = 1'b1;
    @(negedge clk);
    stb = 1'b0;
    repeat (20) @(negedge clk);
    check("midwr.busy", ready, 0);
    #2 rst = 1'b0;
    #1;
    check("arst.scl_oe", scl_oe, 0);
    check("arst.sda_oe", sda_oe, 0);
    check("arst.ready", ready, 1);
    check("arst.err_out", err_out, 0);
    check("arst.data_out", data_out, 0);
    check("arst.ack_out", ack_out, 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("arst.idle_bus", {scl_i, sda_i}, 2'b11);
    check("arst.ready_after", ready, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/i2c_master_core.md
Name: i2c_master_core

Overview:
- Byte-level, single-master I2C engine with an open-drain pad interface.
- A controller issues one command at a time (START, STOP, WRITE byte, READ byte) through a ready/strobe handshake.
- The core generates SCL timing from the system clock, supports slave clock stretching, and reports ACK and error status.
- It sits between peripheral-control FSMs (codec, LED driver and jack-detect sequencers) and the SCL/SDA pads.

Parameters:
- DW, default 4: width of the quarter-period divider. One quarter bit period Q = 2^DW clk cycles, so SCL period = 4·Q.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- scl_oe  out  1  1 = pull SCL low; 0 = release.
- scl_i  in  1  SCL pad level.
- sda_oe  out  1  1 = pull SDA low; 0 = release.
- sda_i  in  1  SDA pad level.
- data_in  in  8  byte for WRITE, MSB first.
- ack_in  in  1  SDA level driven in the ACK slot of READ (0 = ACK, 1 = NAK).
- cmd  in  2  00 START, 01 STOP, 10 WRITE, 11 READ.
- stb  in  1  command strobe, sampled only while ready = 1.
- data_out  out  8  byte received by the last READ.
- ack_out  out  1  ACK-slot level sampled by the last WRITE (0 = slave ACKed).
- err_out  out  1  error flag for the last command.
- ready  out  1  core idle; accepts a command.

Behaviour:
- Reset (rst = 0, async):
  - scl_oe = 0, sda_oe = 0, ready = 1.
  - data_out = 0, ack_out = 0, err_out = 0.
  - Divider and FSM return to IDLE.
  - Reset mid-command aborts immediately and releases both lines.
- Input sync: scl_i and sda_i each pass through a 2-FF synchroniser; all sampling uses the synced values.
- Handshake:
  - On a clk edge with ready = 1 and stb = 1, the core latches cmd, data_in and ack_in, clears err_out, and drives ready = 0 from the next cycle.
  - ready returns to 1 on the cycle the command's last quarter ends.
  - stb while ready = 0 is ignored.
  - cmd, data_in and ack_in may change freely after acceptance.
- FSM states: IDLE, START, STOP, BIT. Quarters Q0..Q3 are each 2^DW cycles, counted by the DW-bit divider.
- START:
  - Q0: SCL low, SDA released.
  - Q1: SCL released.
  - Q2: SDA low.
  - Q3: SCL low.
  - Ends with SCL low, SDA low. The same sequence serves as a repeated START.
- STOP:
  - Q0: SCL low, SDA low.
  - Q1: SCL released.
  - Q2: SDA released.
  - Q3: both released.
  - At the end of Q3, sample SDA; if it is low, set err_out. Ends with the bus idle.
- WRITE: 9 bit slots.
  - Slots 0-7 send data bits MSB first; slot 8 releases SDA for the ACK.
  - ack_out = SDA sampled in slot 8.
- READ: 9 bit slots.
  - Slots 0-7 release SDA and shift the sampled bits MSB first into data_out.
  - Slot 8 drives SDA = ack_in: low if 0, released if 1.
  - data_out updates when the command completes.
- Bit slot:
  - Q0: SCL low; SDA set to the slot value.
  - Q1: SCL low.
  - Q2: SCL released.
  - Q3: SCL high.
  - SDA is sampled on the first cycle of Q3.
  - After slot 8 the core holds SCL low and releases SDA.
- Clock stretching: in Q2 the divider does not advance while synced SCL is low; Q2 counts only once SCL reads high. There is no timeout.
- Arbitration:
  - If, during WRITE slots 0-7, SDA is released (bit = 1) but sampled low, set err_out.
  - Release SDA for all remaining slots of that byte.
  - Complete the command timing normally.
- err_out and ack_out are held until the next accepted command.
- Nominal durations with no stretching: START/STOP = 4·2^DW cycles; WRITE/READ = 36·2^DW cycles.

Decomposition:
- Package i2c_pkg holds the cmd encodings (I2C_CMD_START/STOP/WRITE/READ) and the FSM state enum.
- One natural sub-module: i2c_bit_timer (DW-bit quarter divider with stretch hold, emitting quarter index and quarter-end strobe).
- The 2-FF synchronisers stay inline.

Test Plan (DW = 2, Q = 4 cycles, pads modelled with pull-ups):
- Reset low mid-WRITE -> within one cycle scl_oe = 0, sda_oe = 0, ready = 1, err_out = 0; after release, idle bus.
- START then STOP on an idle bus -> START keeps ready = 0 for 16 cycles with SDA falling while SCL is high; STOP gives SDA rising while SCL is high; err_out = 0.
- START, WRITE 0x30 with the slave pulling SDA low in slot 8, then STOP -> bits 0,0,1,1,0,0,0,0 appear on SDA at SCL rise; WRITE busy for 144 cycles; ack_out = 0.
- WRITE 0x31 with no slave response -> ack_out = 1, err_out = 0.
- READ with ack_in = 1 and the slave driving 0xA5 -> data_out = 0xA5; SDA released in slot 8; stb asserted while busy has no effect.
- Slave holds SCL low 20 cycles in Q2 of bit 3 -> WRITE takes 164 cycles with no bit corruption.
- WRITE 0xFF while another device pulls SDA low in slot 1 -> err_out = 1 at completion and SDA stays released through slot 7.
